vector_dot_acc_pipe: RTL and testbench
======================================

// Module: vector_dot_acc_pipe
// PURPOSE
//  Parametrised, fully pipelined fixed-point dot-product engine for GRU/LSTM gate matrix-vector rows.
//  - Each input beat carries LANES element pairs (a_i, b_i).
//  - Per-beat products are reduced by a registered adder tree, then accumulated across beats until in_last.
//  - Result is rounded, scaled back to Q(FRAC) and emitted as one out_valid pulse per vector.
//  - Sits between weight/activation fetch and the gate activation units.
// PARAMETERS
//  LANES   4   element pairs per beat; any value >=1; tree zero-pads to next power of 2
//  WIDTH   16  signed operand/result width
//  FRAC    12  fractional bits of operands and result (Q(WIDTH-FRAC).FRAC); 1 <= FRAC < WIDTH
//  GUARD   8   extra accumulator headroom bits
//  Derived T = $clog2(LANES) tree stages; ACC_W = 2*WIDTH + T + GUARD
// PORTS
//  clk        in   1              rising-edge clock
//  rst_n      in   1              asynchronous active-low reset
//  clr        in   1              sync flush: drop in-flight beats, clear accumulator
//  in_valid   in   1              beat present on a_flat/b_flat
//  in_last    in   1              qualifies final beat of a vector (ignored when in_valid=0)
//  a_flat     in   LANES*WIDTH    signed operands, lane i at [i*WIDTH +: WIDTH]
//  b_flat     in   LANES*WIDTH    signed operands, same packing
//  out_valid  out  1              one-cycle pulse, result valid
//  out_data   out  WIDTH          signed Q(FRAC) dot product
//  out_ovf    out  1              result was clipped (SAT on) or wrapped (SAT off); valid with out_valid
// BEHAVIOUR
//  - Reset: every pipeline register, accumulator, valid/last tag, out_valid, out_data and out_ovf go to 0.
//  - Reset mid-vector: partial sum is lost; the next beat after reset starts a new vector.
//  - No backpressure: a beat is accepted on every edge with in_valid=1. Throughput is 1 beat/clk.
//  - Stage M (edge E): register LANES full 2*WIDTH signed products plus valid/last tags.
//  - Stages T1..TT: one registered pairwise add level per stage, sign-extended one bit per level.
//    For LANES=1 there are no tree stages.
//  - Stage A (edge E+T+1), on a valid beat:
//    - first = 1 after reset, after clr, or after a last beat.
//    - acc <= first ? tree_sum : acc + tree_sum (ACC_W, two's complement).
//    - Back-to-back vectors need no bubble.
//  - Stage O (edge E+T+2), when the beat in A was last:
//    - r = (acc + 2^(FRAC-1)) >>> FRAC: round half up toward +inf; arithmetic shift.
//    - Narrow r to WIDTH per DOTP_SAT_EN; set out_valid=1 and update out_data and out_ovf.
//    - Otherwise out_valid=0, and out_data/out_ovf hold their last value.
//  - Latency: T+2 cycles from the edge sampling the last beat to out_valid high. LANES=4 gives 4.
//  - in_last on a single-beat vector is legal: result = rounded dot product of that beat.
//  - clr: all valid/last tags in M/T/A/O are cleared on that edge, so no out_valid from in-flight beats.
//    A beat presented with clr is dropped. Accumulator and first flag reset.
//  - The accumulator itself never saturates. ACC_W guarantees >= 2^GUARD beats of full-scale products without wrap.
// CONFIGURATION
//  DOTP_SAT_EN defined:
//    - r > 2^(WIDTH-1)-1 gives out_data = 2^(WIDTH-1)-1 and out_ovf=1.
//    - r < -2^(WIDTH-1) gives out_data = -2^(WIDTH-1) and out_ovf=1.
//    - Otherwise out_data = r and out_ovf=0.
//  DOTP_SAT_EN undefined:
//    - out_data = r[WIDTH-1:0] (wrap, legacy multiplier behaviour).
//    - out_ovf=1 iff the discarded upper bits are not a sign extension.
// TESTING (defaults LANES=4 WIDTH=16 FRAC=12; 1.0 = 4096)
//  1. Single beat, all a=b=4096, last=1 -> 4 cycles later out_valid pulse, out_data=16384, ovf=0.
//  2. Two beats, lane0 a=4096 b=8192 then lane0 a=-4096 b=4096, others 0, last on beat 2
//     -> out_data=4096, exactly one pulse.
//  3. Rounding: lane0 a=1 b=2048 -> out_data=1.
//     Lane0 a=-1 b=2048 -> out_data=0.
//     Lane0 a=-1 b=6144 -> out_data=-1.
//  4. Overflow: two beats all a=b=4096 ->
//     - with DOTP_SAT_EN: out_data=32767, ovf=1;
//     - without: out_data=-32768, ovf=1.
//  5. Back-to-back: 3 single-beat vectors on consecutive clks with dot 1.0, 2.0, 3.0
//     -> pulses on 3 consecutive clks with 4096, 8192, 12288, no cross-vector leakage.
//  6. Disruption, two cases:
//     - clr asserted one clk after a last beat -> no out_valid; next vector's result is correct.
//     - rst_n pulsed mid-vector -> all outputs 0 immediately; next vector's result is correct.

Source files
------------

// File: rtl/vector_dot_acc_pipe_if.sv
// Beat/result bundle for vector_dot_acc_pipe: sync flush, input beats, one result pulse per vector.
interface vector_dot_acc_pipe_if #(
  parameter int LANES = 4,
  parameter int WIDTH = 16
);
  logic                     clr;
  logic                     in_valid;
  logic                     in_last;
  logic [LANES*WIDTH-1:0]   a_flat;
  logic [LANES*WIDTH-1:0]   b_flat;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic                     out_ovf;

  modport master (
    output clr, in_valid, in_last, a_flat, b_flat,
    input  out_valid, out_data, out_ovf
  );

  modport slave (
    input  clr, in_valid, in_last, a_flat, b_flat,
    output out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/vector_dot_acc_pipe.sv
// Pipelined fixed-point dot product: multiply, registered adder tree, cross-beat accumulate, round/narrow.
// Define DOTP_SAT_EN to saturate the narrowed result; otherwise it wraps (legacy behaviour).
module vector_dot_acc_pipe #(
  parameter int LANES = 4,
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int GUARD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_dot_acc_pipe_if.slave dp
);

  localparam int unsigned T     = $clog2(LANES);
  localparam int unsigned P     = 1 << T;
  localparam int unsigned ACC_W = 2*WIDTH + T + GUARD;
  localparam logic signed [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC-1);

  logic signed [ACC_W-1:0] ext  [P];
  logic signed [ACC_W-1:0] tree [T+1][P];
  logic                    vld  [T+1];
  logic                    lst  [T+1];
  logic signed [ACC_W-1:0] acc;
  logic                    started;
  logic                    a_last;
  logic signed [ACC_W:0]   r;
  logic [ACC_W-WIDTH+1:0]  hi;
  logic                    fits;
  logic [WIDTH-1:0]        nxt_data;

  // Products are carried at accumulator width from the start; this is value-identical to
  // growing one bit per tree level and keeps every level the same type.
  always_comb begin
    for (int unsigned j = 0; j < P; j++) ext[j] = '0;
    for (int unsigned i = 0; i < LANES; i++)
      ext[i] = ACC_W'($signed(dp.a_flat[i*WIDTH +: WIDTH]))
             * ACC_W'($signed(dp.b_flat[i*WIDTH +: WIDTH]));
  end

  always_comb begin
    r    = ($signed({acc[ACC_W-1], acc}) + HALF) >>> FRAC;
    hi   = r[ACC_W:WIDTH-1];
    fits = (&hi) | ~(|hi);
`ifdef DOTP_SAT_EN
    if (fits)       nxt_data = r[WIDTH-1:0];
    else if (r[ACC_W]) nxt_data = {1'b1, {(WIDTH-1){1'b0}}};
    else            nxt_data = {1'b0, {(WIDTH-1){1'b1}}};
`else
    nxt_data = r[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k <= T; k++) begin
        for (int unsigned j = 0; j < P; j++) tree[k][j] <= '0;
        vld[k] <= 1'b0;
        lst[k] <= 1'b0;
      end
      acc          <= '0;
      started      <= 1'b0;
      a_last       <= 1'b0;
      dp.out_valid <= 1'b0;
      dp.out_data  <= '0;
      dp.out_ovf   <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < P; j++) tree[0][j] <= ext[j];
      for (int unsigned k = 1; k <= T; k++)
        for (int unsigned j = 0; j < (P >> k); j++)
          tree[k][j] <= tree[k-1][2*j] + tree[k-1][2*j+1];

      vld[0] <= dp.in_valid & ~dp.clr;
      lst[0] <= dp.in_valid & dp.in_last;
      for (int unsigned k = 1; k <= T; k++) begin
        vld[k] <= vld[k-1] & ~dp.clr;
        lst[k] <= lst[k-1];
      end

      if (dp.clr) begin
        acc          <= '0;
        started      <= 1'b0;
        a_last       <= 1'b0;
        dp.out_valid <= 1'b0;
      end else begin
        // started=0 marks the first beat of a vector, so back-to-back vectors need no bubble
        if (vld[T]) begin
          acc     <= started ? acc + tree[T][0] : tree[T][0];
          started <= ~lst[T];
        end
        a_last       <= vld[T] & lst[T];
        dp.out_valid <= a_last;
        if (a_last) begin
          dp.out_data <= nxt_data;
          dp.out_ovf  <= ~fits;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_dot_acc_pipe.sv
// Self-checking bench for vector_dot_acc_pipe (LANES=4 WIDTH=16 FRAC=12); honours DOTP_SAT_EN.
module tb_vector_dot_acc_pipe;

  localparam int LANES = 4;
  localparam int WIDTH = 16;
  localparam int FRAC  = 12;
  localparam int GUARD = 8;

  typedef struct {
    int a[4];
    int b[4];
    int exp_d;
    bit exp_o;
  } vec_t;

  typedef struct {
    logic signed [15:0] d;
    logic               o;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t exp_q[$];
  int   pcyc[$];

  vector_dot_acc_pipe_if #(.LANES(LANES), .WIDTH(WIDTH)) dp ();

  vector_dot_acc_pipe #(.LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC), .GUARD(GUARD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp    (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: exact integer sum, round half up, floor shift, then narrow.
  function automatic exp_t ref_result(input longint sum);
    exp_t   e;
    longint r;
    r   = (sum + (longint'(1) << (FRAC-1))) >>> FRAC;
    e.o = (r > 32767) || (r < -32768);
`ifdef DOTP_SAT_EN
    if (r > 32767)       e.d = 16'sh7fff;
    else if (r < -32768) e.d = 16'sh8000;
    else                 e.d = 16'(r);
`else
    e.d = 16'(r);
`endif
    return e;
  endfunction

  function automatic logic [63:0] pack(input int v0, input int v1, input int v2, input int v3);
    logic [15:0] t0, t1, t2, t3;
    t0 = 16'(v0); t1 = 16'(v1); t2 = 16'(v2); t3 = 16'(v3);
    return {t3, t2, t1, t0};
  endfunction

  task automatic push(input int d, input bit o);
    exp_t e;
    e.d = 16'(d);
    e.o = o;
    exp_q.push_back(e);
  endtask

  task automatic beat(input logic [63:0] a, input logic [63:0] b, input logic last);
    @(negedge clk);
    dp.in_valid = 1'b1;
    dp.in_last  = last;
    dp.a_flat   = a;
    dp.b_flat   = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dp.in_valid = 1'b0;
      dp.in_last  = 1'($urandom);
      dp.a_flat   = {$urandom, $urandom};
      dp.b_flat   = {$urandom, $urandom};
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dp.out_valid) begin
      pcyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual=%0d required=no_pulse", $signed(dp.out_data));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_data", longint'($signed(dp.out_data)), longint'(e.d));
        chk("out_ovf", longint'(dp.out_ovf), longint'(e.o));
      end
    end
  end

  vec_t tbl[6];

  initial begin
    int c0;
    tbl[0] = '{'{4096, 4096, 4096, 4096}, '{4096, 4096, 4096, 4096}, 16384, 1'b0};
    tbl[1] = '{'{1, 0, 0, 0},             '{2048, 0, 0, 0},          1,     1'b0};
    tbl[2] = '{'{-1, 0, 0, 0},            '{2048, 0, 0, 0},          0,     1'b0};
    tbl[3] = '{'{-1, 0, 0, 0},            '{6144, 0, 0, 0},          -1,    1'b0};
    tbl[4] = '{'{0, 4096, 0, 0},          '{0, -4096, 0, 0},         -4096, 1'b0};
`ifdef DOTP_SAT_EN
    tbl[5] = '{'{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}, 32767, 1'b1};
`else
    tbl[5] = '{'{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}, 0, 1'b1};
`endif

    rst_n       = 1'b0;
    dp.clr      = 1'b0;
    dp.in_valid = 1'b0;
    dp.in_last  = 1'b0;
    dp.a_flat   = '0;
    dp.b_flat   = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", longint'(dp.out_valid), 0);
    chk("reset_out_data", longint'(dp.out_data), 0);
    chk("reset_out_ovf", longint'(dp.out_ovf), 0);
    rst_n = 1'b1;

    // latency of a single-beat vector
    pcyc.delete();
    beat(pack(4096, 4096, 4096, 4096), pack(4096, 4096, 4096, 4096), 1'b1);
    c0 = cyc;
    push(16384, 1'b0);
    idle(8);
    chk("latency", (pcyc.size() == 1) ? longint'(pcyc[0] - (c0 + 1)) : -1, 4);

    for (int i = 0; i < 6; i++) begin
      beat(pack(tbl[i].a[0], tbl[i].a[1], tbl[i].a[2], tbl[i].a[3]),
           pack(tbl[i].b[0], tbl[i].b[1], tbl[i].b[2], tbl[i].b[3]), 1'b1);
      push(tbl[i].exp_d, tbl[i].exp_o);
      idle(7);
      chk("table_pending", longint'(exp_q.size()), 0);
    end

    // two-beat vector, exactly one pulse
    pcyc.delete();
    beat(pack(4096, 0, 0, 0), pack(8192, 0, 0, 0), 1'b0);
    beat(pack(-4096, 0, 0, 0), pack(4096, 0, 0, 0), 1'b1);
    push(4096, 1'b0);
    idle(8);
    chk("two_beat_pulses", longint'(pcyc.size()), 1);

    // accumulated overflow over two beats
    beat(pack(4096, 4096, 4096, 4096), pack(4096, 4096, 4096, 4096), 1'b0);
    beat(pack(4096, 4096, 4096, 4096), pack(4096, 4096, 4096, 4096), 1'b1);
`ifdef DOTP_SAT_EN
    push(32767, 1'b1);
`else
    push(-32768, 1'b1);
`endif
    idle(8);
    chk("ovf_pending", longint'(exp_q.size()), 0);

    // back-to-back single-beat vectors
    pcyc.delete();
    beat(pack(4096, 0, 0, 0), pack(4096, 0, 0, 0), 1'b1);
    beat(pack(4096, 0, 0, 0), pack(8192, 0, 0, 0), 1'b1);
    beat(pack(4096, 0, 0, 0), pack(12288, 0, 0, 0), 1'b1);
    push(4096, 1'b0);
    push(8192, 1'b0);
    push(12288, 1'b0);
    idle(8);
    chk("b2b_pulses", longint'(pcyc.size()), 3);
    if (pcyc.size() == 3) begin
      chk("b2b_gap1", longint'(pcyc[1] - pcyc[0]), 1);
      chk("b2b_gap2", longint'(pcyc[2] - pcyc[1]), 1);
    end

    // clr one clk after a last beat; the beat presented with clr is dropped too
    pcyc.delete();
    beat(pack(4096, 0, 0, 0), pack(4096, 0, 0, 0), 1'b1);
    beat(pack(4096, 0, 0, 0), pack(4096, 0, 0, 0), 1'b1);
    dp.clr = 1'b1;
    @(negedge clk);
    dp.clr = 1'b0;
    dp.in_valid = 1'b0;
    idle(7);
    chk("clr_no_pulse", longint'(pcyc.size()), 0);
    beat(pack(4096, 0, 0, 0), pack(8192, 0, 0, 0), 1'b1);
    push(8192, 1'b0);
    idle(8);
    chk("clr_next_pending", longint'(exp_q.size()), 0);

    // async reset mid-vector
    beat(pack(4096, 4096, 0, 0), pack(4096, 4096, 0, 0), 1'b0);
    @(negedge clk);
    dp.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", longint'(dp.out_valid), 0);
    chk("rst_mid_out_data", longint'(dp.out_data), 0);
    chk("rst_mid_out_ovf", longint'(dp.out_ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(pack(4096, 0, 0, 0), pack(12288, 0, 0, 0), 1'b1);
    push(12288, 1'b0);
    idle(8);
    chk("rst_next_pending", longint'(exp_q.size()), 0);

    // randomized multi-beat vectors against the reference
    for (int v = 0; v < 40; v++) begin
      int     nb;
      longint sum;
      nb  = $urandom_range(1, 4);
      sum = 0;
      for (int bt = 0; bt < nb; bt++) begin
        int av[4];
        int bv[4];
        for (int l = 0; l < 4; l++) begin
          logic signed [15:0] ta, tb;
          if ($urandom_range(0, 3) == 0) begin
            ta = 16'($urandom);
            tb = 16'($urandom);
          end else begin
            ta = 16'($urandom_range(0, 12000)) - 16'sd6000;
            tb = 16'($urandom_range(0, 12000)) - 16'sd6000;
          end
          av[l] = int'(ta);
          bv[l] = int'(tb);
          sum += longint'(av[l]) * longint'(bv[l]);
        end
        beat(pack(av[0], av[1], av[2], av[3]), pack(bv[0], bv[1], bv[2], bv[3]), bt == nb - 1);
        if (bt == nb - 1) exp_q.push_back(ref_result(sum));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end
    end
    idle(10);
    chk("final_pending", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
